// File: rtl/datapath_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_ctrl_fsm_pkg
// Purpose  : Shared encodings for the datapath controller: instruction
//            opcode/op fields, ALU and shifter codes, FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package datapath_ctrl_fsm_pkg;

    // Instruction class (IR[15:13])
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    // Sub-operation (IR[12:11]) within each class
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_NOTB   = 2'b11;

    // Shifter control
    localparam logic [1:0] SH_NONE    = 2'b00;
    localparam logic [1:0] SH_LSL     = 2'b01;
    localparam logic [1:0] SH_LSR     = 2'b10;
    localparam logic [1:0] SH_ASR     = 2'b11;

    // Controller states; code 3'b111 is unused and recovers to S_WAIT
    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WIMM   = 3'd2,
        S_GETA   = 3'd3,
        S_GETB   = 3'd4,
        S_EXEC   = 3'd5,
        S_WRES   = 3'd6
    } state_t;

    // ALU op used in the execute stage; MOV reg passes B through an add with 0
    function automatic logic [1:0] exec_aluop(input logic [2:0] opcode,
                                              input logic [1:0] op);
        logic [1:0] r;
        r = ALU_ADD;
        if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  r = ALU_ADD;
                OP_CMP:  r = ALU_SUB;
                OP_AND:  r = ALU_AND;
                default: r = ALU_NOTB;
            endcase
        end
        return r;
    endfunction

    // Single-operand instructions force the A operand to zero
    function automatic logic is_unary(input logic [2:0] opcode,
                                      input logic [1:0] op);
        return ((opcode == OPC_MOV) && (op == OP_MOV_REG)) ||
               ((opcode == OPC_ALU) && (op == OP_MVN));
    endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : datapath_ctrl_fsm_if
// Purpose  : Instruction handshake plus the datapath control bundle.
//            master = instruction source / datapath side, slave = controller.
// Revision : 1.0 - initial release
// ============================================================================
interface datapath_ctrl_fsm_if #(
    parameter int WIDTH = 16
);
    logic             s;
    logic [15:0]      instr;
    logic             w;
    logic             err;
    logic [2:0]       readnum;
    logic [2:0]       writenum;
    logic             loada;
    logic             loadb;
    logic             asel;
    logic             bsel;
    logic [1:0]       shift;
    logic [1:0]       ALUop;
    logic             loadc;
    logic             loads;
    logic             vsel;
    logic             write;
    logic [WIDTH-1:0] datapath_in;

    modport master (
        output s, instr,
        input  w, err, readnum, writenum, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, vsel, write, datapath_in
    );

    modport slave (
        input  s, instr,
        output w, err, readnum, writenum, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, vsel, write, datapath_in
    );
endinterface
`default_nettype wire

// File: rtl/datapath_ctrl_fsm_instr_fields.sv
`default_nettype none
// ============================================================================
// Module   : datapath_ctrl_fsm_instr_fields
// Purpose  : Combinational split of the instruction register into its fields
//            and extension of imm8 to the datapath width.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_ctrl_fsm_instr_fields #(
    parameter int WIDTH      = 16,
    parameter bit IMM_SIGNED = 1'b1
) (
    input  logic [15:0]      ir,
    output logic [2:0]       opcode,
    output logic [1:0]       op,
    output logic [2:0]       rn,
    output logic [2:0]       rd,
    output logic [1:0]       sh,
    output logic [2:0]       rm,
    output logic [WIDTH-1:0] imm_ext
);
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    // Extension is fixed at elaboration, so only one form is built
    generate
        if (IMM_SIGNED) begin : g_sign_ext
            assign imm_ext = {{(WIDTH-8){ir[7]}}, ir[7:0]};
        end else begin : g_zero_ext
            assign imm_ext = {{(WIDTH-8){1'b0}}, ir[7:0]};
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/datapath_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : datapath_ctrl_fsm
// Purpose  : Sequences one 16-bit instruction through register read,
//            execute and writeback, driving the datapath control bundle.
//            All outputs are Moore, decoded from state and IR.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_ctrl_fsm
    import datapath_ctrl_fsm_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit IMM_SIGNED = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    datapath_ctrl_fsm_if.slave  bus
);
    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_ir;
    logic             r_err;
    logic             w_accept;
    logic             w_set_err;

    logic [2:0]       w_opcode;
    logic [1:0]       w_op;
    logic [2:0]       w_rn;
    logic [2:0]       w_rd;
    logic [1:0]       w_sh;
    logic [2:0]       w_rm;
    logic [WIDTH-1:0] w_imm_ext;

    logic             w_w;
    logic [2:0]       w_readnum;
    logic [2:0]       w_writenum;
    logic             w_loada;
    logic             w_loadb;
    logic             w_asel;
    logic             w_bsel;
    logic [1:0]       w_shift;
    logic [1:0]       w_aluop;
    logic             w_loadc;
    logic             w_loads;
    logic             w_vsel;
    logic             w_write;

    datapath_ctrl_fsm_instr_fields #(
        .WIDTH      (WIDTH),
        .IMM_SIGNED (IMM_SIGNED)
    ) u_fields (
        .ir      (r_ir),
        .opcode  (w_opcode),
        .op      (w_op),
        .rn      (w_rn),
        .rd      (w_rd),
        .sh      (w_sh),
        .rm      (w_rm),
        .imm_ext (w_imm_ext)
    );

    // State, IR and sticky error; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ir  <= bus.instr;
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state routing and Moore output decode
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_set_err  = 1'b0;
        w_w        = 1'b0;
        w_readnum  = 3'd0;
        w_writenum = 3'd0;
        w_loada    = 1'b0;
        w_loadb    = 1'b0;
        w_asel     = 1'b0;
        w_bsel     = 1'b0;
        w_shift    = SH_NONE;
        w_aluop    = ALU_ADD;
        w_loadc    = 1'b0;
        w_loads    = 1'b0;
        w_vsel     = 1'b0;
        w_write    = 1'b0;
        case (r_state)
            S_WAIT: begin
                w_w = 1'b1;
                if (bus.s) begin
                    w_accept = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                if ((w_opcode == OPC_MOV) && (w_op == OP_MOV_IMM)) begin
                    w_next = S_WIMM;
                end else if (is_unary(w_opcode, w_op)) begin
                    w_next = S_GETB;
                end else if (w_opcode == OPC_ALU) begin
                    w_next = S_GETA;
                end else begin
                    w_next    = S_WAIT;
                    w_set_err = 1'b1;
                end
            end
            S_WIMM: begin
                w_writenum = w_rn;
                w_vsel     = 1'b1;
                w_write    = 1'b1;
                w_next     = S_WAIT;
            end
            S_GETA: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
                w_next    = S_GETB;
            end
            S_GETB: begin
                w_readnum = w_rm;
                w_loadb   = 1'b1;
                w_next    = S_EXEC;
            end
            S_EXEC: begin
                w_shift = w_sh;
                w_bsel  = 1'b0;
                w_asel  = is_unary(w_opcode, w_op);
                w_aluop = exec_aluop(w_opcode, w_op);
                if ((w_opcode == OPC_ALU) && (w_op == OP_CMP)) begin
                    w_loads = 1'b1;
                    w_next  = S_WAIT;
                end else begin
                    w_loadc = 1'b1;
                    w_next  = S_WRES;
                end
            end
            S_WRES: begin
                w_writenum = w_rd;
                w_vsel     = 1'b0;
                w_write    = 1'b1;
                w_next     = S_WAIT;
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

    assign bus.w           = w_w;
    assign bus.err         = r_err;
    assign bus.readnum     = w_readnum;
    assign bus.writenum    = w_writenum;
    assign bus.loada       = w_loada;
    assign bus.loadb       = w_loadb;
    assign bus.asel        = w_asel;
    assign bus.bsel        = w_bsel;
    assign bus.shift       = w_shift;
    assign bus.ALUop       = w_aluop;
    assign bus.loadc       = w_loadc;
    assign bus.loads       = w_loads;
    assign bus.vsel        = w_vsel;
    assign bus.write       = w_write;
    assign bus.datapath_in = w_imm_ext;
endmodule
`default_nettype wire
